// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int UART_MIN_DATA_BITS = 5;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchroniser for an asynchronous level input
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], d};
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver: start detect, mid-bit majority vote, framed byte delivery
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              baud_tick,
   input  logic              rx_pin,
   input  logic [3:0]        cfg_data_bits,
   input  logic              cfg_parity_en,
   input  logic              cfg_parity_odd,
   input  logic              cfg_stop2,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_perr,
   output logic              rx_ferr,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_V0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [3:0]    DW4    = 4'(DATA_W);
   localparam logic [3:0]    MIN4   = 4'(UART_MIN_DATA_BITS);

   rx_state_e         state, state_nxt;
   logic              rx_sync;
   logic              armed;
   logic [TW-1:0]     tick_cnt;
   logic [3:0]        bit_cnt;
   logic [1:0]        vote_sr;
   logic [DATA_W-1:0] data_sr;
   logic              par_acc, perr_acc, ferr_acc;
   logic [3:0]        fr_bits;
   logic              fr_par_en, fr_par_odd, fr_stop2;
   logic              vote_now, in_window, last_data, stop_more, start_det, deliver;

   bit_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_pin),
      .q     (rx_sync)
   );

   // Vote uses the two earlier window samples plus the live synchronised level.
   assign vote_now  = maj3(vote_sr[1], vote_sr[0], rx_sync);
   assign in_window = (state != IDLE) && (tick_cnt >= T_V0) && (tick_cnt <= T_VOTE);
   assign last_data = (bit_cnt == fr_bits - 4'd1);
   assign stop_more = fr_stop2 && (bit_cnt == 4'd0);
   assign start_det = baud_tick && (state == IDLE) && armed && !rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (baud_tick) begin
         case (state)
            IDLE:   if (armed && !rx_sync) state_nxt = START;
            START:  begin
               if (tick_cnt == T_VOTE && vote_now) state_nxt = IDLE;
               else if (tick_cnt == T_LAST)        state_nxt = DATA;
            end
            DATA:   if (tick_cnt == T_LAST && last_data) state_nxt = fr_par_en ? PARITY : STOP;
            PARITY: if (tick_cnt == T_LAST) state_nxt = STOP;
            STOP:   if (tick_cnt == T_VOTE && !stop_more) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      deliver = baud_tick && (state == STOP) && (tick_cnt == T_VOTE) && !stop_more;
      rx_busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         vote_sr    <= '0;
         data_sr    <= '0;
         par_acc    <= 1'b0;
         perr_acc   <= 1'b0;
         ferr_acc   <= 1'b0;
         fr_bits    <= DW4;
         fr_par_en  <= 1'b0;
         fr_par_odd <= 1'b0;
         fr_stop2   <= 1'b0;
      end else if (baud_tick) begin
         if (rx_sync) armed <= 1'b1;
         if (state == IDLE || state_nxt == IDLE || tick_cnt == T_LAST) tick_cnt <= '0;
         else                                                          tick_cnt <= tick_cnt + 1'b1;
         if (in_window) vote_sr <= {vote_sr[0], rx_sync};

         if (tick_cnt == T_LAST || state == IDLE) begin
            if (state == DATA && !last_data) bit_cnt <= bit_cnt + 4'd1;
            else if (state == STOP)          bit_cnt <= 4'd1;
            else                             bit_cnt <= 4'd0;
         end

         if (start_det) begin
            fr_bits    <= (cfg_data_bits < MIN4 || cfg_data_bits > DW4) ? DW4 : cfg_data_bits;
            fr_par_en  <= cfg_parity_en;
            fr_par_odd <= cfg_parity_odd;
            fr_stop2   <= cfg_stop2;
            data_sr    <= '0;
            par_acc    <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
         end else if (tick_cnt == T_VOTE) begin
            case (state)
               DATA: begin
                  data_sr <= data_sr | (DATA_W'(vote_now) << bit_cnt);
                  par_acc <= par_acc ^ vote_now;
               end
               PARITY:  perr_acc <= par_acc ^ vote_now ^ fr_par_odd;
               STOP:    ferr_acc <= ferr_acc | !vote_now;
               default: ;
            endcase
         end
      end
   end

   // A frame completing while the previous one is still unaccepted is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_perr    <= 1'b0;
         rx_ferr    <= 1'b0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (deliver && (!rx_valid || rx_ready)) begin
            rx_data  <= data_sr;
            rx_perr  <= perr_acc;
            rx_ferr  <= ferr_acc | !vote_now;
            rx_valid <= 1'b1;
         end else begin
            if (deliver)               rx_overrun <= 1'b1;
            if (rx_valid && rx_ready)  rx_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_tick = 1'b0;
   logic       rx_pin = 1'b1;
   logic [3:0] cfg_data_bits = 4'd8;
   logic       cfg_parity_en = 1'b0;
   logic       cfg_parity_odd = 1'b0;
   logic       cfg_stop2 = 1'b0;
   logic [7:0] rx_data;
   logic       rx_perr, rx_ferr, rx_valid, rx_overrun, rx_busy;
   logic       rx_ready = 1'b1;

   int total = 0;
   int bad = 0;
   int div = 0;
   int ovr_cnt = 0;
   logic [7:0] q_data[$];
   logic       q_perr[$];
   logic       q_ferr[$];

   uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .baud_tick      (baud_tick),
      .rx_pin         (rx_pin),
      .cfg_data_bits  (cfg_data_bits),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop2      (cfg_stop2),
      .rx_data        (rx_data),
      .rx_perr        (rx_perr),
      .rx_ferr        (rx_ferr),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .rx_overrun     (rx_overrun),
      .rx_busy        (rx_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      div = (div == 3) ? 0 : div + 1;
      baud_tick = (div == 0);
   end

   always @(negedge clk) begin
      if (rx_valid && rx_ready) begin
         q_data.push_back(rx_data);
         q_perr.push_back(rx_perr);
         q_ferr.push_back(rx_ferr);
      end
      if (rx_overrun) ovr_cnt++;
   end

   task automatic drive_bit(input logic b);
      rx_pin = b;
      repeat (64) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input logic s1, input logic two, input logic s2);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (par_en) drive_bit(par_bit);
      drive_bit(s1);
      if (two) drive_bit(s2);
      rx_pin = 1'b1;
      repeat (128) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [3:0] bits, input logic pen, input logic podd, input logic st2);
      cfg_data_bits  = bits;
      cfg_parity_en  = pen;
      cfg_parity_odd = podd;
      cfg_stop2      = st2;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      total++; if ({rx_perr, rx_ferr, rx_overrun} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b exp=000", {rx_perr, rx_ferr, rx_overrun});
      end
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_8n1;
      int n0 = q_data.size();
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL 8n1_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h exp=a5", q_data[n0]); end
         total++; if (q_perr[n0] !== 1'b0) begin bad++; $display("FAIL 8n1_perr got=%b exp=0", q_perr[n0]); end
         total++; if (q_ferr[n0] !== 1'b0) begin bad++; $display("FAIL 8n1_ferr got=%b exp=0", q_ferr[n0]); end
      end
   endtask

   task automatic test_parity;
      int n0 = q_data.size();
      set_cfg(4'd8, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q_data.size() - n0 !== 2) begin
         bad++; $display("FAIL par_count got=%0d exp=2", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'h03) begin bad++; $display("FAIL par_data got=%h exp=03", q_data[n0]); end
         total++; if (q_perr[n0] !== 1'b1) begin bad++; $display("FAIL par_bad_perr got=%b exp=1", q_perr[n0]); end
         total++; if (q_perr[n0+1] !== 1'b0) begin bad++; $display("FAIL par_good_perr got=%b exp=0", q_perr[n0+1]); end
         total++; if (q_ferr[n0+1] !== 1'b0) begin bad++; $display("FAIL par_ferr got=%b exp=0", q_ferr[n0+1]); end
      end
   endtask

   task automatic test_7o2_ferr;
      int n0 = q_data.size();
      set_cfg(4'd7, 1'b1, 1'b1, 1'b1);
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL 7o2_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'h41) begin bad++; $display("FAIL 7o2_data got=%h exp=41", q_data[n0]); end
         total++; if (q_ferr[n0] !== 1'b1) begin bad++; $display("FAIL 7o2_ferr got=%b exp=1", q_ferr[n0]); end
         total++; if (q_perr[n0] !== 1'b0) begin bad++; $display("FAIL 7o2_perr got=%b exp=0", q_perr[n0]); end
      end
   endtask

   task automatic test_5n1;
      int n0 = q_data.size();
      set_cfg(4'd5, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL 5n1_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'h1F) begin bad++; $display("FAIL 5n1_data got=%h exp=1f", q_data[n0]); end
      end
   endtask

   task automatic test_cfg_clamp;
      int n0 = q_data.size();
      set_cfg(4'd2, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL clamp_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'hC3) begin bad++; $display("FAIL clamp_data got=%h exp=c3", q_data[n0]); end
      end
   endtask

   task automatic test_glitch;
      int n0 = q_data.size();
      int cyc = 0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      rx_pin = 1'b0;
      repeat (24) @(negedge clk);
      rx_pin = 1'b1;
      total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_set got=%b exp=1", rx_busy); end
      while (rx_busy === 1'b1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_clear got=%b exp=0", rx_busy); end
      repeat (128) @(negedge clk);
      total++; if (q_data.size() - n0 !== 0) begin bad++; $display("FAIL glitch_frames got=%0d exp=0", q_data.size() - n0); end
   endtask

   task automatic test_back_to_back;
      int n0 = q_data.size();
      int o0 = ovr_cnt;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rx_ready = 1'b0;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held got=%b exp=1", rx_valid); end
      total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data_held got=%h exp=11", rx_data); end
      total++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
      @(posedge clk); #1;
      rx_ready = 1'b1;
      repeat (8) @(negedge clk);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL ovr_accept_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'h11) begin bad++; $display("FAIL ovr_accept_data got=%h exp=11", q_data[n0]); end
      end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_clear got=%b exp=0", rx_valid); end
   endtask

   task automatic test_reset_low_line;
      int n0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      rx_pin = 1'b0;
      rst_n  = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      n0 = q_data.size();
      repeat (640) @(negedge clk);
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL unarmed_busy got=%b exp=0", rx_busy); end
      total++; if (q_data.size() - n0 !== 0) begin bad++; $display("FAIL unarmed_frames got=%0d exp=0", q_data.size() - n0); end
      rx_pin = 1'b1;
      repeat (64) @(negedge clk);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q_data.size() - n0 !== 1) begin
         bad++; $display("FAIL rearm_count got=%0d exp=1", q_data.size() - n0);
      end else begin
         total++; if (q_data[n0] !== 8'h5A) begin bad++; $display("FAIL rearm_data got=%h exp=5a", q_data[n0]); end
         total++; if (q_ferr[n0] !== 1'b0) begin bad++; $display("FAIL rearm_ferr got=%b exp=0", q_ferr[n0]); end
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_7o2_ferr();
      test_5n1();
      test_cfg_clamp();
      test_glitch();
      test_back_to_back();
      test_reset_low_line();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
